vga_sync: RTL

Timing generator for the 640x480@60 Hz VGA path. It divides the system clock down to a pixel-rate enable and runs horizontal and vertical scan counters. It drives the monitor's hsync/vsync pins. Its pix_x/pix_y and video_on outputs feed the text painter and the downstream RGB multiplexer directly.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_sync_mod_n_counter.sv | 39 +++
 rtl/vga_sync.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants, shared by the sync generator, text painter and RGB mux.
package vga_timing_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Counter width for a modulus; a mod-1 counter still needs one (constant) bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_mod_n_counter.sv
// Enabled modulo-N counter with a wrap pulse and an exposed next-state value.
module mod_n_counter #(
    parameter int N     = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

    logic [WIDTH-1:0] count_reg;
    logic             at_last;

    assign at_last = (count_reg == LAST);
    assign wrap    = enable && at_last;
    assign count   = count_reg;

    // count_next is the non-reset successor; callers apply reset themselves.
    always_comb begin
        count_next = count_reg;
        if (enable) begin
            count_next = at_last ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate enable, horizontal/vertical scan counters and sync decode.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY   = VGA_H_DISPLAY,
    parameter int   H_FRONT     = VGA_H_FRONT,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BACK      = VGA_H_BACK,
    parameter int   V_DISPLAY   = VGA_V_DISPLAY,
    parameter int   V_FRONT     = VGA_V_FRONT,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BACK      = VGA_V_BACK,
    parameter int   TICK_DIV    = 2,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_end,
    output logic               frame_end
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = cnt_width(TICK_DIV);

    localparam coord_t H_VISIBLE  = coord_t'(H_DISPLAY);
    localparam coord_t V_VISIBLE  = coord_t'(V_DISPLAY);
    localparam coord_t H_SYNC_LO  = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t H_SYNC_HI  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t V_SYNC_LO  = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t V_SYNC_HI  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_count;
    logic [DIV_W-1:0] div_count_next;
    logic             tick;
    coord_t           h_count;
    coord_t           h_next;
    logic             h_wrap;
    coord_t           v_count;
    coord_t           v_next;
    logic             v_wrap;
    logic             div_unused;

    logic hsync_reg;
    logic vsync_reg;
    logic video_on_reg;

    // Divider runs freely; its wrap pulse is the pixel enable.
    mod_n_counter #(
        .N     (TICK_DIV),
        .WIDTH (DIV_W)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .enable     (1'b1),
        .count      (div_count),
        .count_next (div_count_next),
        .wrap       (tick)
    );

    mod_n_counter #(
        .N     (H_TOTAL),
        .WIDTH (COORD_W)
    ) u_h (
        .clk        (clk),
        .reset      (reset),
        .enable     (tick),
        .count      (h_count),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    mod_n_counter #(
        .N     (V_TOTAL),
        .WIDTH (COORD_W)
    ) u_v (
        .clk        (clk),
        .reset      (reset),
        .enable     (h_wrap),
        .count      (v_count),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    assign div_unused = ^{div_count, div_count_next};

    // Decoding next-state coordinates keeps syncs and video_on aligned with pix_x/pix_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_reg    <= ~SYNC_ACTIVE;
            vsync_reg    <= ~SYNC_ACTIVE;
            video_on_reg <= 1'b1;
        end else begin
            hsync_reg    <= in_window(h_next, H_SYNC_LO, H_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_reg    <= in_window(v_next, V_SYNC_LO, V_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on_reg <= (h_next < H_VISIBLE) && (v_next < V_VISIBLE);
        end
    end

    assign p_tick    = tick;
    assign pix_x     = h_count;
    assign pix_y     = v_count;
    assign hsync     = hsync_reg;
    assign vsync     = vsync_reg;
    assign video_on  = video_on_reg;
    assign line_end  = h_wrap;
    assign frame_end = v_wrap;

endmodule
